// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares a single-port 1-cycle-latency data memory between the
// pipeline MEM stage (P) and the loader/debug engine (L).
//   clk, reset                  : clock, asynchronous active-high reset
//   p_req/p_we/p_addr/p_wdata   : pipeline request
//   p_stall/p_rdata/p_rvalid    : pipeline hold and read return
//   l_req/l_we/l_lock/l_addr/l_wdata : loader request (l_lock extends a granted burst)
//   l_gnt/l_rdata/l_rvalid      : loader grant and read return
//   mem_en/mem_we/mem_addr/mem_din/mem_dout : memory pins
module dm_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_stall,
    output logic [DW-1:0] p_rdata,
    output logic          p_rvalid,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic [DW-1:0] l_rdata,
    output logic          l_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_P = 2'd1;
    localparam logic [1:0] OWN_L = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       locked;
    logic [1:0] rd_owner;
    logic       grant_p;
    logic       grant_l;

    // L wins when its burst is locked, when it is alone, or when P has won too often
    always_comb begin
        grant_l = l_req & (locked | ~p_req | (starve_cnt >= STARVE_LIM));
        grant_p = p_req & ~grant_l;
    end

    always_comb begin
        mem_en   = grant_p | grant_l;
        mem_we   = grant_l ? l_we : grant_p & p_we;
        mem_addr = grant_l ? l_addr : grant_p ? p_addr : '0;
        mem_din  = grant_l ? l_wdata : grant_p ? p_wdata : '0;
        p_stall  = p_req & ~grant_p;
        l_gnt    = grant_l;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            locked     <= 1'b0;
            rd_owner   <= OWN_NONE;
        end else begin
            if (grant_l)
                starve_cnt <= '0;
            else if (grant_p & l_req & (starve_cnt != 4'hF))
                starve_cnt <= starve_cnt + 4'd1;
            locked   <= grant_l & l_lock;
            rd_owner <= (grant_l & ~l_we) ? OWN_L : (grant_p & ~p_we) ? OWN_P : OWN_NONE;
        end
    end

    // Fixed 1-cycle memory latency: the single owner tag steers this cycle's mem_dout
    always_comb begin
        p_rvalid = rd_owner == OWN_P;
        l_rvalid = rd_owner == OWN_L;
        p_rdata  = p_rvalid ? mem_dout : '0;
        l_rdata  = l_rvalid ? mem_dout : '0;
    end
endmodule
